// File: rtl/baccarat_pkg.sv
// baccarat_pkg: round states, card rank constants and the rank-to-value helper.
package baccarat_pkg;
    typedef enum logic [3:0] {
        S_P1, S_D1, S_P2, S_D2, S_CHK, S_P3, S_BNK, S_D3, S_RES, S_DONE
    } state_e;

    localparam logic [3:0] ACE = 4'd1;
    localparam logic [3:0] TEN = 4'd10;
    localparam logic [3:0] KING = 4'd13;
    localparam logic [3:0] NATURAL_MIN = 4'd8;

    function automatic logic [3:0] card_value(input logic [3:0] rank);
        return (rank >= TEN && rank <= KING) ? 4'd0 : rank;
    endfunction
endpackage

// File: rtl/baccarat_banker_rule.sv
// baccarat_banker_rule: banker third-card draw decision from the banker total and
// the value of the player's third card.
module baccarat_banker_rule (
    input  logic [3:0] dscore,
    input  logic [3:0] pvalue,
    output logic       draw
);
    assign draw = (dscore <= 4'd2)
               || (dscore == 4'd3 && pvalue != 4'd8)
               || (dscore == 4'd4 && pvalue >= 4'd2 && pvalue <= 4'd7)
               || (dscore == 4'd5 && pvalue >= 4'd4 && pvalue <= 4'd7)
               || (dscore == 4'd6 && pvalue >= 4'd6 && pvalue <= 4'd7);
endmodule

// File: rtl/baccarat_sequencer.sv
// baccarat_sequencer: steps one baccarat round, strobing card loads and latching win lights.
// Define BACCARAT_TALLY_EN to add saturating player/dealer/tie tally outputs.
module baccarat_sequencer
`ifdef BACCARAT_TALLY_EN
    #(parameter int TALLY_W = 8)
`endif
(
    input  logic       slow_clock,
    input  logic       reset,
    input  logic       step,
    input  logic [3:0] pscore,
    input  logic [3:0] dscore,
    input  logic [3:0] pcard3,
    output logic       load_pcard1,
    output logic       load_pcard2,
    output logic       load_pcard3,
    output logic       load_dcard1,
    output logic       load_dcard2,
    output logic       load_dcard3,
    output logic       clear_hand,
    output logic       player_win_light,
    output logic       dealer_win_light,
    output logic       done
`ifdef BACCARAT_TALLY_EN
    ,
    output logic [TALLY_W-1:0] player_wins,
    output logic [TALLY_W-1:0] dealer_wins,
    output logic [TALLY_W-1:0] ties
`endif
);
    import baccarat_pkg::*;

    state_e state_q, state_d;
    logic pwin_q, pwin_d, dwin_q, dwin_d, done_q, done_d;
    logic adv, bank_draw;
    logic [3:0] pvalue;

    // Reset wins over step, so a strobe never fires on a reset edge.
    assign adv = step && !reset;
    assign pvalue = card_value(pcard3);

    baccarat_banker_rule u_banker (
        .dscore(dscore),
        .pvalue(pvalue),
        .draw  (bank_draw)
    );

    assign load_pcard1 = adv && state_q == S_P1;
    assign load_dcard1 = adv && state_q == S_D1;
    assign load_pcard2 = adv && state_q == S_P2;
    assign load_dcard2 = adv && state_q == S_D2;
    assign load_pcard3 = adv && state_q == S_P3;
    assign load_dcard3 = adv && state_q == S_D3;
    assign clear_hand = load_pcard1;
    assign player_win_light = pwin_q;
    assign dealer_win_light = dwin_q;
    assign done = done_q;

    always_comb begin
        state_d = state_q;
        pwin_d = pwin_q;
        dwin_d = dwin_q;
        done_d = done_q;
        if (step) begin
            unique case (state_q)
                S_P1: state_d = S_D1;
                S_D1: state_d = S_P2;
                S_P2: state_d = S_D2;
                S_D2: state_d = S_CHK;
                S_CHK: state_d = (pscore >= NATURAL_MIN || dscore >= NATURAL_MIN) ? S_RES :
                                 (pscore <= 4'd5) ? S_P3 :
                                 (dscore <= 4'd5) ? S_D3 : S_RES;
                S_P3: state_d = S_BNK;
                S_BNK: state_d = bank_draw ? S_D3 : S_RES;
                S_D3: state_d = S_RES;
                S_RES: begin
                    pwin_d = pscore >= dscore;
                    dwin_d = dscore >= pscore;
                    done_d = 1'b1;
                    state_d = S_DONE;
                end
                S_DONE: begin
                    pwin_d = 1'b0;
                    dwin_d = 1'b0;
                    done_d = 1'b0;
                    state_d = S_P1;
                end
                default: state_d = S_P1;
            endcase
        end
    end

`ifdef BACCARAT_TALLY_EN
    logic [TALLY_W-1:0] pw_q, pw_d, dw_q, dw_d, tie_q, tie_d;
    logic tally;

    assign tally = step && state_q == S_RES;
    assign player_wins = pw_q;
    assign dealer_wins = dw_q;
    assign ties = tie_q;

    always_comb begin
        pw_d = (tally && pscore > dscore && !(&pw_q)) ? pw_q + TALLY_W'(1) : pw_q;
        dw_d = (tally && dscore > pscore && !(&dw_q)) ? dw_q + TALLY_W'(1) : dw_q;
        tie_d = (tally && pscore == dscore && !(&tie_q)) ? tie_q + TALLY_W'(1) : tie_q;
    end
`endif

    always_ff @(posedge slow_clock) begin
        if (reset) begin
            state_q <= S_P1;
            pwin_q <= 1'b0;
            dwin_q <= 1'b0;
            done_q <= 1'b0;
`ifdef BACCARAT_TALLY_EN
            pw_q <= '0;
            dw_q <= '0;
            tie_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            pwin_q <= pwin_d;
            dwin_q <= dwin_d;
            done_q <= done_d;
`ifdef BACCARAT_TALLY_EN
            pw_q <= pw_d;
            dw_q <= dw_d;
            tie_q <= tie_d;
`endif
        end
    end
endmodule

// File: tb/tb_baccarat_sequencer.sv
// tb_baccarat_sequencer: directed table rounds, hold/reset corners and random rounds
// checked against a card-level baccarat model.
module tb_baccarat_sequencer;
    logic slow_clock = 1'b0;
    logic reset = 1'b1;
    logic step = 1'b0;
    logic [3:0] pscore = 4'd0, dscore = 4'd0, pcard3 = 4'd1;
    logic load_pcard1, load_pcard2, load_pcard3, load_dcard1, load_dcard2, load_dcard3;
    logic clear_hand, player_win_light, dealer_win_light, done;
    logic [6:0] strb;
`ifdef BACCARAT_TALLY_EN
    logic [7:0] player_wins, dealer_wins, ties;
`endif

    baccarat_sequencer dut (
        .slow_clock(slow_clock), .reset(reset), .step(step),
        .pscore(pscore), .dscore(dscore), .pcard3(pcard3),
        .load_pcard1(load_pcard1), .load_pcard2(load_pcard2), .load_pcard3(load_pcard3),
        .load_dcard1(load_dcard1), .load_dcard2(load_dcard2), .load_dcard3(load_dcard3),
        .clear_hand(clear_hand), .player_win_light(player_win_light),
        .dealer_win_light(dealer_win_light), .done(done)
`ifdef BACCARAT_TALLY_EN
        , .player_wins(player_wins), .dealer_wins(dealer_wins), .ties(ties)
`endif
    );

    always #5 slow_clock = ~slow_clock;

    assign strb = {clear_hand, load_pcard1, load_pcard2, load_pcard3,
                   load_dcard1, load_dcard2, load_dcard3};

    localparam logic [6:0] NONE = 7'b0000000;
    localparam logic [6:0] ST_P1 = 7'b1100000;
    localparam logic [6:0] ST_P2 = 7'b0010000;
    localparam logic [6:0] ST_P3 = 7'b0001000;
    localparam logic [6:0] ST_D1 = 7'b0000100;
    localparam logic [6:0] ST_D2 = 7'b0000010;
    localparam logic [6:0] ST_D3 = 7'b0000001;

    // Banker tableau: row = banker total, bit v set = banker draws on player third value v.
    logic [9:0] tableau [8] = '{10'h3FF, 10'h3FF, 10'h3FF, 10'h2FF,
                                10'h0FC, 10'h0F0, 10'h0C0, 10'h000};

    int checks = 0;
    int failures = 0;
    int pt = 0, dt = 0;

    typedef struct {
        logic [3:0] pchk, dchk, pc3, pfin, dfin;
        logic p3, d3, pw, dw;
    } vec_t;
    vec_t tbl [16];

    function automatic int cval(input logic [3:0] r);
        return (r > 4'd9) ? 0 : int'(r);
    endfunction

    task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic do_step(input logic [6:0] exp, input logic [3:0] ps, input logic [3:0] ds,
                           input logic [3:0] pc3, input string nm);
        @(negedge slow_clock);
        step = 1'b1;
        pscore = ps;
        dscore = ds;
        pcard3 = pc3;
        #1;
        check(nm, 16'(strb), 16'(exp));
        @(posedge slow_clock);
        #1;
        step = 1'b0;
    endtask

    task automatic chk_lights(input logic pw, input logic dw, input logic dn, input string nm);
        check(nm, 16'({player_win_light, dealer_win_light, done}), 16'({pw, dw, dn}));
    endtask

    task automatic do_reset();
        @(negedge slow_clock);
        reset = 1'b1;
        step = 1'b0;
        @(posedge slow_clock);
        @(posedge slow_clock);
        #1;
        reset = 1'b0;
    endtask

`ifdef BACCARAT_TALLY_EN
    task automatic natural_round(input logic [3:0] ps, input logic [3:0] ds);
        do_step(ST_P1, ps, ds, 4'd1, "tally_p1");
        do_step(ST_D1, ps, ds, 4'd1, "tally_d1");
        do_step(ST_P2, ps, ds, 4'd1, "tally_p2");
        do_step(ST_D2, ps, ds, 4'd1, "tally_d2");
        do_step(NONE, ps, ds, 4'd1, "tally_chk");
        do_step(NONE, ps, ds, 4'd1, "tally_res");
        do_step(NONE, ps, ds, 4'd1, "tally_done");
    endtask
`endif

    initial begin
        tbl[0]  = '{4'd8, 4'd3, 4'd1,  4'd8, 4'd3, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[1]  = '{4'd6, 4'd4, 4'd1,  4'd6, 4'd7, 1'b0, 1'b1, 1'b0, 1'b1};
        tbl[2]  = '{4'd3, 4'd6, 4'd7,  4'd0, 4'd9, 1'b1, 1'b1, 1'b0, 1'b1};
        tbl[3]  = '{4'd3, 4'd6, 4'd12, 4'd3, 4'd6, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[4]  = '{4'd2, 4'd2, 4'd3,  4'd5, 4'd5, 1'b1, 1'b1, 1'b1, 1'b1};
        tbl[5]  = '{4'd9, 4'd9, 4'd1,  4'd9, 4'd9, 1'b0, 1'b0, 1'b1, 1'b1};
        tbl[6]  = '{4'd6, 4'd6, 4'd1,  4'd6, 4'd6, 1'b0, 1'b0, 1'b1, 1'b1};
        tbl[7]  = '{4'd4, 4'd7, 4'd13, 4'd4, 4'd7, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[8]  = '{4'd0, 4'd3, 4'd8,  4'd8, 4'd3, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[9]  = '{4'd7, 4'd0, 4'd5,  4'd7, 4'd2, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[10] = '{4'd5, 4'd3, 4'd10, 4'd5, 4'd9, 1'b1, 1'b1, 1'b0, 1'b1};
        tbl[11] = '{4'd1, 4'd5, 4'd4,  4'd5, 4'd6, 1'b1, 1'b1, 1'b0, 1'b1};
        tbl[12] = '{4'd1, 4'd5, 4'd3,  4'd4, 4'd5, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[13] = '{4'd1, 4'd6, 4'd6,  4'd7, 4'd6, 1'b1, 1'b1, 1'b1, 1'b0};
        tbl[14] = '{4'd1, 4'd4, 4'd1,  4'd2, 4'd4, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[15] = '{4'd2, 4'd8, 4'd1,  4'd2, 4'd8, 1'b0, 1'b0, 1'b0, 1'b1};

        do_reset();
        #1;
        check("reset_strobes", 16'(strb), 16'(NONE));
        chk_lights(1'b0, 1'b0, 1'b0, "reset_lights");

        // Hold in S_P2 with step low, then confirm it still deals player card 2.
        do_step(ST_P1, 4'd0, 4'd0, 4'd1, "hold_p1");
        do_step(ST_D1, 4'd0, 4'd0, 4'd1, "hold_d1");
        for (int i = 0; i < 10; i++) begin
            @(negedge slow_clock);
            step = 1'b0;
            #1;
            check("hold_strobes", 16'(strb), 16'(NONE));
        end
        do_step(ST_P2, 4'd0, 4'd0, 4'd1, "hold_p2");
        do_step(ST_D2, 4'd0, 4'd0, 4'd1, "hold_d2");
        do_step(NONE, 4'd6, 4'd4, 4'd1, "hold_chk");

        // Now in S_D3: reset with step high must suppress load_dcard3.
        @(negedge slow_clock);
        step = 1'b1;
        reset = 1'b1;
        #1;
        check("rst_d3_strobe", 16'(strb), 16'(NONE));
        @(posedge slow_clock);
        #1;
        reset = 1'b0;
        step = 1'b0;
        chk_lights(1'b0, 1'b0, 1'b0, "rst_d3_lights");
        do_step(ST_P1, 4'd0, 4'd0, 4'd1, "rst_then_p1");
        do_reset();

        for (int i = 0; i < 16; i++) begin
            do_step(ST_P1, 4'd0, 4'd0, tbl[i].pc3, $sformatf("t%0d_p1", i));
            do_step(ST_D1, 4'd0, 4'd0, tbl[i].pc3, $sformatf("t%0d_d1", i));
            do_step(ST_P2, 4'd0, 4'd0, tbl[i].pc3, $sformatf("t%0d_p2", i));
            do_step(ST_D2, 4'd0, 4'd0, tbl[i].pc3, $sformatf("t%0d_d2", i));
            do_step(NONE, tbl[i].pchk, tbl[i].dchk, tbl[i].pc3, $sformatf("t%0d_chk", i));
            if (tbl[i].p3) begin
                do_step(ST_P3, tbl[i].pchk, tbl[i].dchk, tbl[i].pc3, $sformatf("t%0d_p3", i));
                do_step(NONE, tbl[i].pfin, tbl[i].dchk, tbl[i].pc3, $sformatf("t%0d_bnk", i));
            end
            if (tbl[i].d3)
                do_step(ST_D3, tbl[i].pfin, tbl[i].dchk, tbl[i].pc3, $sformatf("t%0d_d3", i));
            chk_lights(1'b0, 1'b0, 1'b0, $sformatf("t%0d_pre_res", i));
            do_step(NONE, tbl[i].pfin, tbl[i].dfin, tbl[i].pc3, $sformatf("t%0d_res", i));
            chk_lights(tbl[i].pw, tbl[i].dw, 1'b1, $sformatf("t%0d_lights", i));
            do_step(NONE, tbl[i].pfin, tbl[i].dfin, tbl[i].pc3, $sformatf("t%0d_done", i));
            chk_lights(1'b0, 1'b0, 1'b0, $sformatf("t%0d_cleared", i));
        end

        // Random rounds: the bench plays the cards itself and derives every strobe.
        for (int n = 0; n < 60; n++) begin
            logic [3:0] r [6];
            int v [6];
            int b;
            for (int k = 0; k < 6; k++) begin
                r[k] = 4'($urandom_range(1, 13));
                v[k] = cval(r[k]);
            end
            do_step(ST_P1, 4'(pt), 4'(dt), r[4], "rnd_p1");
            pt = v[0];
            dt = 0;
            do_step(ST_D1, 4'(pt), 4'(dt), r[4], "rnd_d1");
            dt = v[1];
            do_step(ST_P2, 4'(pt), 4'(dt), r[4], "rnd_p2");
            pt = (pt + v[2]) % 10;
            do_step(ST_D2, 4'(pt), 4'(dt), r[4], "rnd_d2");
            dt = (dt + v[3]) % 10;
            do_step(NONE, 4'(pt), 4'(dt), r[4], "rnd_chk");
            if (!(pt >= 8 || dt >= 8)) begin
                if (pt <= 5) begin
                    do_step(ST_P3, 4'(pt), 4'(dt), r[4], "rnd_p3");
                    pt = (pt + v[4]) % 10;
                    b = dt;
                    do_step(NONE, 4'(pt), 4'(dt), r[4], "rnd_bnk");
                    if (tableau[b][v[4]]) begin
                        do_step(ST_D3, 4'(pt), 4'(dt), r[4], "rnd_d3");
                        dt = (dt + v[5]) % 10;
                    end
                end else if (dt <= 5) begin
                    do_step(ST_D3, 4'(pt), 4'(dt), r[4], "rnd_d3s");
                    dt = (dt + v[5]) % 10;
                end
            end
            do_step(NONE, 4'(pt), 4'(dt), r[4], "rnd_res");
            chk_lights(pt > dt || pt == dt, dt > pt || pt == dt, 1'b1, "rnd_lights");
            do_step(NONE, 4'(pt), 4'(dt), r[4], "rnd_done");
            chk_lights(1'b0, 1'b0, 1'b0, "rnd_cleared");
        end

`ifdef BACCARAT_TALLY_EN
        do_reset();
        #1;
        check("tally_reset", 16'({player_wins, dealer_wins}), 16'h0000);
        for (int i = 0; i < 3; i++) natural_round(4'd8, 4'd3);
        natural_round(4'd9, 4'd9);
        check("tally_player3", 16'(player_wins), 16'd3);
        check("tally_tie1", 16'(ties), 16'd1);
        for (int i = 0; i < 300; i++) natural_round(4'd3, 4'd8);
        check("tally_player", 16'(player_wins), 16'd3);
        check("tally_tie", 16'(ties), 16'd1);
        check("tally_dealer_sat", 16'(dealer_wins), 16'd255);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
